game_state_ctrl: RTL and testbench

Sequencer for the game-state register bank (`game_retract`) in the Sokoban core.
- Accepts player commands (move, undo, restart) through a valid/ready port, and level-load requests from the level loader.
- Arbitrates between the two sources.
- Drives the move logic through a start/done handshake.
- Issues the one-cycle `sel` / `game_state_en` strobes that commit, retract or reload the 134-bit game state.
- Tracks the step count and the available undo depth.

---
 rtl/game_state_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: arbitrates player commands and level loads into game_retract strobes.
// Build option GSC_MULTI_UNDO_EN: undo history up to UNDO_DEPTH (1..15), else single undo.
module game_state_ctrl #(
    parameter int UNDO_DEPTH = 8,
    parameter int STEP_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_dir,
    input  logic              load_req,
    output logic              load_ack,
    output logic              move_start,
    output logic [1:0]        move_dir,
    input  logic              move_done,
    input  logic              move_legal,
    input  logic              real_retract,
    output logic [1:0]        sel,
    output logic              game_state_en,
    output logic [STEP_W-1:0] step_cnt,
    output logic [3:0]        undo_avail,
    output logic              busy,
    output logic              cmd_err
);

`ifdef GSC_MULTI_UNDO_EN
    localparam bit MultiUndo = 1'b1;
`else
    localparam bit MultiUndo = 1'b0;
`endif
    localparam logic [3:0] UndoCap = MultiUndo ? 4'(UNDO_DEPTH) : 4'd1;

    localparam logic [1:0] OpMove    = 2'd0;
    localparam logic [1:0] OpUndo    = 2'd1;
    localparam logic [1:0] OpRestart = 2'd2;

    localparam logic [1:0] SelInit    = 2'd0;
    localparam logic [1:0] SelMove    = 2'd1;
    localparam logic [1:0] SelRetract = 2'd2;
    localparam logic [1:0] SelHold    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE,
        S_COMMIT,
        S_UNDO,
        S_UNDO_CHK
    } state_e;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              load_ack_q, load_ack_d;
    logic              move_start_q, move_start_d;
    logic [1:0]        move_dir_q, move_dir_d;
    logic [1:0]        sel_q, sel_d;
    logic              en_q, en_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [3:0]        undo_q, undo_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    // load_req must win in the same cycle it rises, so it gates the registered ready
    assign cmd_ready     = ready_q && !load_req;
    assign load_ack      = load_ack_q;
    assign move_start    = move_start_q;
    assign move_dir      = move_dir_q;
    assign sel           = sel_q;
    assign game_state_en = en_q;
    assign step_cnt      = step_q;
    assign undo_avail    = undo_q;
    assign busy          = busy_q;
    assign cmd_err       = err_q;

    always_comb begin
        state_d      = state_q;
        move_dir_d   = move_dir_q;
        step_d       = step_q;
        undo_d       = undo_q;
        load_ack_d   = 1'b0;
        move_start_d = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d    = S_LOAD;
                    load_ack_d = 1'b1;
                end else if (cmd_valid && cmd_ready) begin
                    unique case (cmd_op)
                        OpMove: begin
                            state_d      = S_MOVE;
                            move_dir_d   = cmd_dir;
                            move_start_d = 1'b1;
                        end
                        OpUndo: begin
                            if (undo_q == 4'd0) err_d = 1'b1;
                            else                state_d = S_UNDO;
                        end
                        OpRestart: state_d = S_LOAD;
                        default:   err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                step_d  = '0;
                undo_d  = '0;
                state_d = S_IDLE;
            end
            S_MOVE: begin
                if (move_done) begin
                    state_d = move_legal ? S_COMMIT : S_IDLE;
                    err_d   = !move_legal;
                end
            end
            S_COMMIT: begin
                if (step_q != '1)     step_d = step_q + STEP_W'(1);
                if (undo_q < UndoCap) undo_d = undo_q + 4'd1;
                state_d = S_IDLE;
            end
            S_UNDO: state_d = S_UNDO_CHK;
            S_UNDO_CHK: begin
                if (real_retract) begin
                    if (step_q != '0)   step_d = step_q - STEP_W'(1);
                    if (undo_q != 4'd0) undo_d = undo_q - 4'd1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // strobes are decoded from the state being entered so they leave a flop
        sel_d = SelHold;
        en_d  = 1'b0;
        case (state_d)
            S_LOAD: begin
                sel_d = SelInit;
                en_d  = 1'b1;
            end
            S_COMMIT: begin
                sel_d = SelMove;
                en_d  = 1'b1;
            end
            S_UNDO: begin
                sel_d = SelRetract;
                en_d  = 1'b1;
            end
            default: ;
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            load_ack_q   <= 1'b0;
            move_start_q <= 1'b0;
            move_dir_q   <= 2'd0;
            sel_q        <= SelHold;
            en_q         <= 1'b0;
            step_q       <= '0;
            undo_q       <= 4'd0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            load_ack_q   <= load_ack_d;
            move_start_q <= move_start_d;
            move_dir_q   <= move_dir_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            step_q       <= step_d;
            undo_q       <= undo_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed scenarios plus random traffic against a
// transaction-script model of the sequencer.
module tb_game_state_ctrl;

    localparam int STEP_W   = 8;
    localparam int STEP_MAX = (1 << STEP_W) - 1;
`ifdef GSC_MULTI_UNDO_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op, cmd_dir;
    logic              load_req, load_ack;
    logic              move_start;
    logic [1:0]        move_dir;
    logic              move_done, move_legal, real_retract;
    logic [1:0]        sel;
    logic              game_state_en;
    logic [STEP_W-1:0] step_cnt;
    logic [3:0]        undo_avail;
    logic              busy, cmd_err;

    game_state_ctrl #(.UNDO_DEPTH(8), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dir(cmd_dir),
        .load_req(load_req), .load_ack(load_ack),
        .move_start(move_start), .move_dir(move_dir),
        .move_done(move_done), .move_legal(move_legal),
        .real_retract(real_retract),
        .sel(sel), .game_state_en(game_state_en),
        .step_cnt(step_cnt), .undo_avail(undo_avail),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    // Model: each cycle is a frame of expected outputs; a command expands
    // into a script of frames, an action is applied when its frame ends.
    localparam logic [2:0] A_NONE = 3'd0;
    localparam logic [2:0] A_CLR  = 3'd1;
    localparam logic [2:0] A_INC  = 3'd2;
    localparam logic [2:0] A_CHK  = 3'd3;
    localparam logic [2:0] A_WAIT = 3'd4;

    typedef struct packed {
        logic [1:0] sel;
        logic       en, busy, ack, err, start, rdy;
        logic [2:0] act;
    } frame_t;

    function automatic frame_t mk(input logic [1:0] s, input logic en,
                                  input logic ack, input logic start,
                                  input logic [2:0] act);
        frame_t f;
        f.sel = s; f.en = en; f.busy = 1'b1; f.ack = ack;
        f.err = 1'b0; f.start = start; f.rdy = 1'b0; f.act = act;
        return f;
    endfunction

    function automatic frame_t idle_f(input logic err);
        frame_t f;
        f = mk(2'd3, 1'b0, 1'b0, 1'b0, A_NONE);
        f.busy = 1'b0; f.rdy = 1'b1; f.err = err;
        return f;
    endfunction

    frame_t     cur, nx;
    frame_t     script[$];
    int         m_step, m_undo;
    logic [1:0] m_dir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur = idle_f(1'b0);
            cur.rdy = 1'b0;
            script.delete();
            m_step = 0; m_undo = 0; m_dir = 2'd0;
        end else begin
            nx = idle_f(1'b0);
            case (cur.act)
                A_CLR: begin m_step = 0; m_undo = 0; end
                A_INC: begin
                    if (m_step < STEP_MAX) m_step++;
                    if (m_undo < CAP) m_undo++;
                end
                A_CHK: begin
                    if (real_retract) begin
                        if (m_step > 0) m_step--;
                        if (m_undo > 0) m_undo--;
                    end else nx.err = 1'b1;
                end
                A_WAIT: begin
                    if (!move_done) nx = mk(2'd3, 1'b0, 1'b0, 1'b0, A_WAIT);
                    else if (move_legal) nx = mk(2'd1, 1'b1, 1'b0, 1'b0, A_INC);
                    else nx.err = 1'b1;
                end
                default: ;
            endcase
            if (script.size() != 0) nx = script.pop_front();
            else if (!cur.busy) begin
                if (load_req) nx = mk(2'd0, 1'b1, 1'b1, 1'b0, A_CLR);
                else if (cur.rdy && cmd_valid) begin
                    case (cmd_op)
                        2'd0: begin
                            m_dir = cmd_dir;
                            nx = mk(2'd3, 1'b0, 1'b0, 1'b1, A_WAIT);
                        end
                        2'd1: begin
                            if (m_undo == 0) nx.err = 1'b1;
                            else begin
                                nx = mk(2'd2, 1'b1, 1'b0, 1'b0, A_NONE);
                                script.push_back(mk(2'd3, 1'b0, 1'b0, 1'b0, A_CHK));
                            end
                        end
                        2'd2: nx = mk(2'd0, 1'b1, 1'b0, 1'b0, A_CLR);
                        default: nx.err = 1'b1;
                    endcase
                end
            end
            cur = nx;
        end
    end

    int en_seen = 0, sel1_seen = 0, sel2_seen = 0, err_seen = 0;

    always @(negedge clk) begin
        chk("sel", int'(sel), int'(cur.sel));
        chk("game_state_en", int'(game_state_en), int'(cur.en));
        chk("busy", int'(busy), int'(cur.busy));
        chk("load_ack", int'(load_ack), int'(cur.ack));
        chk("cmd_err", int'(cmd_err), int'(cur.err));
        chk("move_start", int'(move_start), int'(cur.start));
        chk("cmd_ready", int'(cmd_ready), int'(cur.rdy && !load_req));
        chk("step_cnt", int'(step_cnt), m_step);
        chk("undo_avail", int'(undo_avail), m_undo);
        chk("move_dir", int'(move_dir), int'(m_dir));
        if (game_state_en) en_seen++;
        if (game_state_en && sel == 2'd1) sel1_seen++;
        if (game_state_en && sel == 2'd2) sel2_seen++;
        if (cmd_err) err_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] dir);
        bit acc = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic do_move(input logic [1:0] dir, input logic legal, input int dly);
        send_cmd(2'd0, dir);
        repeat (dly) tick();
        move_done = 1'b1; move_legal = legal;
        tick();
        move_done = 1'b0;
    endtask

    task automatic do_undo(input logic rr);
        send_cmd(2'd1, 2'd0);
        real_retract = rr;
        tick(); tick();
        real_retract = 1'b0;
    endtask

    int s_en, s_sel1, s_sel2, s_err;

    task automatic snap();
        s_en = en_seen; s_sel1 = sel1_seen; s_sel2 = sel2_seen; s_err = err_seen;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dir = 2'd0;
        load_req = 1'b1; move_done = 1'b0; move_legal = 1'b0; real_retract = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_sel", int'(sel), 3);
        tick();
        rst_n = 1'b1;
        tick();
        load_req = 1'b0;
        @(negedge clk);
        chk("rel_load_sel", int'(sel), 0);
        chk("rel_load_en", int'(game_state_en), 1);
        chk("rel_load_ack", int'(load_ack), 1);
        chk("rel_load_step", int'(step_cnt), 0);
        tick();

        snap();
        do_move(2'd2, 1'b1, 3);
        repeat (2) tick();
        chk("mv_dir", int'(move_dir), 2);
        chk("mv_commits", sel1_seen - s_sel1, 1);
        chk("mv_step", int'(step_cnt), 1);
        chk("mv_undo", int'(undo_avail), 1);

        send_cmd(2'd2, 2'd0);
        tick();
        snap();
        do_move(2'd0, 1'b1, 1);
        do_move(2'd3, 1'b1, 1);
        do_undo(1'b1);
        do_undo(1'b1);
        repeat (2) tick();
`ifdef GSC_MULTI_UNDO_EN
        chk("uu_retracts", sel2_seen - s_sel2, 2);
        chk("uu_step", int'(step_cnt), 0);
        chk("uu_err", err_seen - s_err, 0);
`else
        chk("uu_retracts", sel2_seen - s_sel2, 1);
        chk("uu_step", int'(step_cnt), 1);
        chk("uu_err", err_seen - s_err, 1);
`endif

        send_cmd(2'd2, 2'd0);
        repeat (2) tick();
        snap();
        send_cmd(2'd1, 2'd0);
        send_cmd(2'd3, 2'd0);
        repeat (2) tick();
        chk("rej_err", err_seen - s_err, 2);
        chk("rej_en", en_seen - s_en, 0);
        chk("rej_busy", int'(busy), 0);

        load_req = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dir = 2'd1;
        @(negedge clk);
        chk("race_ready", int'(cmd_ready), 0);
        tick();
        load_req = 1'b0;
        @(negedge clk);
        chk("race_ack", int'(load_ack), 1);
        chk("race_move_start", int'(move_start), 0);
        do_move(2'd1, 1'b1, 2);
        repeat (2) tick();
        chk("race_dir", int'(move_dir), 1);
        chk("race_step", int'(step_cnt), 1);

        for (int i = 0; i < 260; i++) do_move(2'(i), 1'b1, 0);
        repeat (2) tick();
        chk("sat_step", int'(step_cnt), STEP_MAX);
        chk("sat_undo", int'(undo_avail), CAP);

        snap();
        send_cmd(2'd0, 2'd3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_step", int'(step_cnt), 0);
        chk("mrst_dir", int'(move_dir), 0);
        chk("mrst_ready", int'(cmd_ready), 0);
        tick(); tick();
        rst_n = 1'b1;
        move_done = 1'b1; move_legal = 1'b1;
        tick();
        move_done = 1'b0;
        repeat (4) tick();
        chk("mrst_no_strobe", en_seen - s_en, 0);

        for (int c = 0; c < 3000; c++) begin
            cmd_valid    = ($urandom_range(0, 2) != 0);
            cmd_op       = 2'($urandom_range(0, 3));
            cmd_dir      = 2'($urandom_range(0, 3));
            load_req     = ($urandom_range(0, 15) == 0);
            move_done    = ($urandom_range(0, 3) == 0);
            move_legal   = ($urandom_range(0, 3) != 0);
            real_retract = ($urandom_range(0, 3) != 0);
            rst_n        = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_n = 1'b1; cmd_valid = 1'b0; load_req = 1'b0; move_done = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
